// File: rtl/fsmc_pkg.sv
// Shared definitions for the FSMC initiator and its responder-side bench:
// state encoding, default bus timing and widths.
package fsmc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } fsmc_state_e;

  localparam int unsigned FSMC_ADDR_W = 2;
  localparam int unsigned FSMC_DATA_W = 16;
  localparam int unsigned FSMC_ADDSET = 2;
  localparam int unsigned FSMC_DATAST = 4;
  localparam int unsigned FSMC_HOLD   = 1;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fsmc_initiator.sv
// FSMC-style asynchronous 16-bit bus master: one request at a time, programmable
// setup/strobe/hold timing, read data or write ack returned on a one-cycle pulse.
module fsmc_initiator
  import fsmc_pkg::*;
#(
  parameter int unsigned ADDR_W = FSMC_ADDR_W,
  parameter int unsigned DATA_W = FSMC_DATA_W,
  parameter int unsigned ADDSET = FSMC_ADDSET,
  parameter int unsigned DATAST = FSMC_DATAST,
  parameter int unsigned HOLD   = FSMC_HOLD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              nce,
  output logic              noe,
  output logic              nwe,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data
);

  localparam int unsigned CNT_W = $clog2(max3(ADDSET, DATAST, HOLD)) + 1;

  fsmc_state_e       state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              oe_q;
  logic              nce_q;
  logic              noe_q;
  logic              nwe_q;
  logic              ready_q;
  logic              rsp_valid_q;

  // Phase sequencer; the down-counter is reloaded on each state entry and the
  // phase ends when it reaches zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      oe_q        <= 1'b0;
      nce_q       <= 1'b1;
      noe_q       <= 1'b1;
      nwe_q       <= 1'b1;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            state_q <= ST_SETUP;
            cnt_q   <= CNT_W'(ADDSET - 1);
            ready_q <= 1'b0;
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            oe_q    <= req_write;
            nce_q   <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (cnt_q == '0) begin
            state_q <= ST_STROBE;
            cnt_q   <= CNT_W'(DATAST - 1);
            noe_q   <= write_q;
            nwe_q   <= ~write_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_STROBE: begin
          if (cnt_q == '0) begin
            // Sample the bus while noe is still low.
            if (!write_q) begin
              rdata_q <= data;
            end
            state_q     <= ST_HOLD;
            cnt_q       <= CNT_W'(HOLD - 1);
            nce_q       <= 1'b1;
            noe_q       <= 1'b1;
            nwe_q       <= 1'b1;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            oe_q    <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign nce       = nce_q;
  assign noe       = noe_q;
  assign nwe       = nwe_q;
  assign addr      = addr_q;
  assign data      = oe_q ? wdata_q : {DATA_W{1'bz}};

endmodule
